// File: rtl/mem_multicycle_resp_if.sv
// Request/response bundle for the multicycle memory responder.
// master = requester (pipeline or cache-fill logic), slave = memory responder.
interface mem_multicycle_resp_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 4
) ();

  logic                  req_en;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_wdata;
  logic                  rsp_valid;
  logic [15:0]           rsp_data;
  logic [CNT_WIDTH-1:0]  rd_pending;

  modport master (
    output req_en, req_wr, req_addr, req_wdata,
    input  rsp_valid, rsp_data, rd_pending
  );

  modport slave (
    input  req_en, req_wr, req_addr, req_wdata,
    output rsp_valid, rsp_data, rd_pending
  );

endinterface

// File: rtl/mem_multicycle_resp.sv
// Multicycle memory responder: word-addressed 16-bit storage with a fixed
// LATENCY-cycle, fully pipelined read path. Reads return in issue order with
// rsp_valid; writes produce no response. Reads snapshot the word at issue, so
// later writes never disturb data already in flight.
//
// Optional build macro MEM_ALIGN_CHECK_EN: adds the misalign output and rejects
// requests with req_addr[0] = 1. Without it, odd addresses alias to the even word.
module mem_multicycle_resp #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 misalign,
`endif
  mem_multicycle_resp_if.slave bus
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 1);

  logic [ADDR_WIDTH-2:0] word_addr;
  logic                  accept;
  logic                  wr_fire;
  logic                  rd_fire;

  assign word_addr = bus.req_addr[ADDR_WIDTH-1:1];

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_reg;

  // Odd-address requests are dropped; flag them for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= bus.req_en && bus.req_addr[0];
    end
  end

  assign misalign = misalign_reg;
  assign accept   = bus.req_en && !bus.req_addr[0] && !rst;
`else
  // Byte-lane bit is architecturally ignored in this build.
  logic unused_addr_lsb;
  assign unused_addr_lsb = bus.req_addr[0];
  assign accept          = bus.req_en && !rst;
`endif

  // Requests seen while rst is high are ignored entirely, writes included.
  assign wr_fire = accept && bus.req_wr;
  assign rd_fire = accept && !bus.req_wr;

  // ---------------------------------------------------------------------------
  // Storage: not reset, one write port and a registered read (read-first).
  // ---------------------------------------------------------------------------
  logic [15:0] mem_array [WORDS];
  logic [15:0] rd_word_reg;

  // Write on accepted write requests; capture the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_array[word_addr] <= bus.req_wdata;
    end
    rd_word_reg <= mem_array[word_addr];
  end

  // ---------------------------------------------------------------------------
  // Response pipeline. Stage 1 is the array read register; stages 2..LATENCY
  // are plain {valid, data} shift stages. Data is zeroed when not valid so the
  // output stays quiet between responses.
  // ---------------------------------------------------------------------------
  logic [LATENCY:1] stg_vld;
  logic [15:0]      stg_data [1:LATENCY];
  logic             rd_vld_reg;

  // Valid bit that accompanies the array read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_reg <= 1'b0;
    end else begin
      rd_vld_reg <= rd_fire;
    end
  end

  assign stg_vld[1]  = rd_vld_reg;
  assign stg_data[1] = rd_word_reg;

  genvar gi;
  generate
    for (gi = 2; gi <= LATENCY; gi++) begin : g_stage
      logic        vld_reg;
      logic [15:0] data_reg;

      // Advance one pipeline stage; reset discards anything in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg  <= 1'b0;
          data_reg <= 16'h0000;
        end else begin
          vld_reg  <= stg_vld[gi-1];
          data_reg <= stg_vld[gi-1] ? stg_data[gi-1] : 16'h0000;
        end
      end

      assign stg_vld[gi]  = vld_reg;
      assign stg_data[gi] = data_reg;
    end
  endgenerate

  assign bus.rsp_valid = stg_vld[LATENCY];
  assign bus.rsp_data  = stg_vld[LATENCY] ? stg_data[LATENCY] : 16'h0000;

  // ---------------------------------------------------------------------------
  // In-flight read counter. Bounded by LATENCY since every read leaves the
  // pipeline exactly LATENCY cycles after it entered.
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] pend_reg;
  logic [CNT_WIDTH-1:0] pend_next;

  // +1 per read issue, -1 per returned response, net zero when both occur.
  always_comb begin
    pend_next = pend_reg;
    if (rd_fire && !bus.rsp_valid) begin
      pend_next = pend_reg + CNT_WIDTH'(1);
    end else if (!rd_fire && bus.rsp_valid) begin
      pend_next = pend_reg - CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  assign bus.rd_pending = pend_reg;

endmodule
